// File: rtl/sorted_ram_writer.sv
// Writer side of the 32x8 search RAM: inserts one byte per start edge while keeping
// entries 0..count-1 in non-decreasing order, using a shift-up insertion scan from the top.
module sorted_ram_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic              rejected,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, CMP, PLACE, DONE} state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  state_t              state_reg, state_next;
  logic                start_q_reg;
  logic                rejected_reg;
  logic [DATA_W-1:0]   v_reg;
  logic [ADDR_W-1:0]   i_reg;
  logic [ADDR_W-1:0]   pos_reg;
  logic [ADDR_W:0]     count_reg;
  logic                start_edge;
  logic                is_full;
  logic                is_empty;
  logic                shift;

  assign start_edge = start & ~start_q_reg;
  assign is_full    = (count_reg == FULL_COUNT);
  assign is_empty   = (count_reg == '0);
  // Strictly greater: equal entries stay below the new one, so insertion is stable.
  assign shift      = (ram_q > v_reg);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q_reg  <= 1'b0;
      rejected_reg <= 1'b0;
      v_reg        <= '0;
      i_reg        <= '0;
      pos_reg      <= '0;
      count_reg    <= '0;
    end else begin
      start_q_reg  <= start;
      rejected_reg <= (state_reg == IDLE) && start_edge && is_full;
      case (state_reg)
        IDLE: begin
          if (start_edge && !is_full) begin
            v_reg <= data_in;
            if (is_empty) pos_reg <= '0;
            else          i_reg   <= ADDR_W'(count_reg - 1'b1);
          end
        end
        CMP: begin
          if (shift) begin
            if (i_reg == '0) pos_reg <= '0;
            else             i_reg   <= i_reg - 1'b1;
          end else begin
            pos_reg <= i_reg + 1'b1;
          end
        end
        PLACE:   count_reg <= count_reg + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_edge && !is_full) state_next = is_empty ? PLACE : READ;
      end
      READ:  state_next = WAIT;
      WAIT:  state_next = CMP;
      CMP: begin
        if (shift && (i_reg != '0)) state_next = READ;
        else                        state_next = PLACE;
      end
      PLACE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_wren = 1'b0;
    case (state_reg)
      READ, WAIT: ram_addr = i_reg;
      CMP: begin
        ram_addr = i_reg;
        if (shift) begin
          ram_addr = i_reg + 1'b1;
          ram_data = ram_q;
          ram_wren = 1'b1;
        end
      end
      PLACE: begin
        ram_addr = pos_reg;
        ram_data = v_reg;
        ram_wren = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = (state_reg == READ) || (state_reg == WAIT) ||
                    (state_reg == CMP)  || (state_reg == PLACE);
  assign done     = (state_reg == DONE);
  assign rejected = rejected_reg;
  assign count    = count_reg;

endmodule

// File: tb/tb_sorted_ram_writer.sv
// Directed bench for sorted_ram_writer with a registered-read RAM model attached to its port.
module tb_sorted_ram_writer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic [7:0] ram_q;
  logic [4:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic       busy;
  logic       done;
  logic       rejected;
  logic [5:0] count;

  logic [7:0] mem [0:31];
  int         write_count;
  int         vec_count;
  int         miscompare_count;
  logic       prev_wren;
  logic [4:0] prev_addr;

  sorted_ram_writer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .ram_q    (ram_q),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren),
    .busy     (busy),
    .done     (done),
    .rejected (rejected),
    .count    (count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompare_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM model: write on wren, registered read of the presented address.
  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_addr] <= ram_data;
      write_count   <= write_count + 1;
    end
    ram_q <= mem[ram_addr];
    if (ram_wren && prev_wren)
      check_value("consec_same_addr", 32'(ram_addr == prev_addr), 32'd0);
    prev_wren <= ram_wren;
    prev_addr <= ram_addr;
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Presses start with val and returns after done; checks latency and write count.
  task automatic do_insert(input logic [7:0] val, input int exp_lat, input int exp_writes);
    int cyc;
    int w0;
    @(negedge clk);
    data_in = val;
    start   = 1'b1;
    w0      = write_count;
    cyc     = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 300);
    $display("insert 0x%02h: done after %0d cycles, %0d writes, count %0d",
             val, cyc, write_count - w0, count);
    check_value("done_latency", 32'(cyc), 32'(exp_lat));
    check_value("write_pulses", 32'(write_count - w0), 32'(exp_writes));
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int dones;
    int w0;
    vec_count        = 0;
    miscompare_count = 0;
    write_count      = 0;
    prev_wren        = 1'b0;
    prev_addr        = '0;
    reset            = 1'b1;
    start            = 1'b0;
    data_in          = '0;
    for (int k = 0; k < 32; k++) mem[k] = 8'h00;

    // Reset state
    apply_reset();
    check_value("rst_count", 32'(count), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_done", 32'(done), 32'd0);
    check_value("rst_rejected", 32'(rejected), 32'd0);
    check_value("rst_wren", 32'(ram_wren), 32'd0);
    check_value("rst_addr", 32'(ram_addr), 32'd0);

    // Empty table: direct PLACE
    do_insert(8'h05, 2, 1);
    check_value("empty_count", 32'(count), 32'd1);
    check_value("empty_mem0", 32'(mem[0]), 32'h05);

    // Ascending inserts, then one below everything, then a duplicate
    apply_reset();
    do_insert(8'h10, 2, 1);
    do_insert(8'h20, 5, 1);
    do_insert(8'h30, 5, 1);
    check_value("asc_count", 32'(count), 32'd3);
    do_insert(8'h01, 11, 4);
    check_value("low_mem0", 32'(mem[0]), 32'h01);
    check_value("low_mem1", 32'(mem[1]), 32'h10);
    check_value("low_mem2", 32'(mem[2]), 32'h20);
    check_value("low_mem3", 32'(mem[3]), 32'h30);
    do_insert(8'h20, 8, 2);
    check_value("dup_count", 32'(count), 32'd5);
    check_value("dup_mem3", 32'(mem[3]), 32'h20);
    check_value("dup_mem4", 32'(mem[4]), 32'h30);

    // Reset during WAIT of a 3-shift insert
    apply_reset();
    do_insert(8'h10, 2, 1);
    do_insert(8'h20, 5, 1);
    do_insert(8'h30, 5, 1);
    @(negedge clk);
    data_in = 8'h01;
    start   = 1'b1;
    @(negedge clk);
    check_value("mid_busy_read", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    $display("reset in WAIT: busy %0d count %0d done %0d", busy, count, done);
    check_value("mid_busy", 32'(busy), 32'd0);
    check_value("mid_count", 32'(count), 32'd0);
    check_value("mid_wren", 32'(ram_wren), 32'd0);
    reset = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_value("mid_no_done", 32'(dones), 32'd0);

    // Fill to 32 ascending, then a rejected press
    apply_reset();
    for (int k = 0; k < 32; k++) do_insert(8'(k * 4), (k == 0) ? 2 : 5, 1);
    check_value("full_count", 32'(count), 32'd32);
    for (int k = 0; k < 32; k += 7) check_value("full_mem", 32'(mem[k]), 32'(k * 4));
    w0 = write_count;
    @(negedge clk);
    data_in = 8'h00;
    start   = 1'b1;
    @(negedge clk);
    $display("press while full: rejected %0d busy %0d", rejected, busy);
    check_value("rej_pulse", 32'(rejected), 32'd1);
    check_value("rej_busy", 32'(busy), 32'd0);
    check_value("rej_done", 32'(done), 32'd0);
    @(negedge clk);
    check_value("rej_once", 32'(rejected), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check_value("rej_no_write", 32'(write_count - w0), 32'd0);
    check_value("rej_count", 32'(count), 32'd32);

    // Held start gives one insert; re-press gives a second
    apply_reset();
    @(negedge clk);
    data_in = 8'h42;
    start   = 1'b1;
    dones   = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) dones++;
    end
    $display("start held 50 cycles: %0d done pulses, count %0d", dones, count);
    check_value("hold_one_done", 32'(dones), 32'd1);
    check_value("hold_count", 32'(count), 32'd1);
    start = 1'b0;
    @(negedge clk);
    do_insert(8'h42, 5, 1);
    check_value("repress_count", 32'(count), 32'd2);
    check_value("repress_mem0", 32'(mem[0]), 32'h42);
    check_value("repress_mem1", 32'(mem[1]), 32'h42);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

endmodule
